fifo_stream_drain: RTL and testbench

FIFO_STREAM_DRAIN -- requirements
Module: fifo_stream_drain

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/stream_skid_buf.sv | 93 +++++++++
 rtl/fifo_stream_drain.sv | 93 +++++++++
 tb/tb_fifo_stream_drain.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: default word width and depth,
// plus the occupancy encoding of the 2-entry output buffer.
// No ports; imported by stream_skid_buf and fifo_stream_drain.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 16;

  // Occupancy of the in-order output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_count(input occ_e s);
    logic [1:0] n;
    case (s)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// 2-entry in-order output buffer with EMPTY/ONE/TWO occupancy state machine.
// Latency: a word captured on one edge is presented on m_valid_o/m_data_o right after it.
// Backpressure: head held stable while m_ready_i is low; the caller must never capture into a full buffer.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   cap_vld_i/_dat_i - write a word into the buffer tail this cycle
//   m_ready_i      - sink accepts the head word (pop when m_valid_o is high)
//   m_valid_o/_data_o - registered head of the buffer
//   occ_o          - current occupancy state
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = fifo_pkg::FIFO_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cap_vld_i,
  input  logic [W-1:0] cap_dat_i,
  input  logic         m_ready_i,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  output occ_e         occ_o
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop;

  assign pop = (occ_q != EMPTY) && m_ready_i;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({cap_vld_i, pop})
      2'b10: begin
        case (occ_q)
          EMPTY: begin
            head_d = cap_dat_i;
            occ_d  = ONE;
          end
          ONE: begin
            tail_d = cap_dat_i;
            occ_d  = TWO;
          end
          // Capture into a full buffer cannot happen: the read request
          // logic upstream never lets occupancy plus in-flight exceed 2.
          default: ;
        endcase
      end
      2'b01: begin
        case (occ_q)
          ONE:     occ_d = EMPTY;
          TWO: begin
            head_d = tail_q;
            occ_d  = ONE;
          end
          default: ;
        endcase
      end
      2'b11: begin
        // Occupancy unchanged; the head advances to the next word in order.
        case (occ_q)
          ONE: head_d = cap_dat_i;
          TWO: begin
            head_d = tail_q;
            tail_d = cap_dat_i;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign m_valid_o = (occ_q != EMPTY);
  assign m_data_o  = head_q;
  assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream.
// Latency: 2 cycles from first fifo_rd_en to m_valid; one word per cycle sustained.
// Backpressure: reads stop once buffered plus in-flight words reach 2; m_data held while stalled.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   enable                    - drain permitted
//   fifo_empty/_underflow/_data_out - FIFO status and read data
//   fifo_rd_en                - FIFO read request
//   m_valid/m_ready/m_data    - output stream
//   word_cnt                  - delivered-word count (wraps)
//   err_underflow             - sticky FIFO underflow flag
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  err_underflow
);

  logic                 armed_q, armed_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                 err_q, err_d;
  occ_e                 occ;
  logic                 pop;
  logic [2:0]           budget;
  logic                 rd_en;

  stream_skid_buf #(
    .W (FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .cap_vld_i (inflight_q),
    .cap_dat_i (fifo_data_out),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .occ_o     (occ)
  );

  assign pop = m_valid && m_ready;

  // Occupancy is counted after this cycle's pop so a slot freed by the sink
  // can be refilled in the same cycle; without that credit the drain would
  // only move a word every other cycle.
  assign budget = {1'b0, occ_count(occ)} - {2'b00, pop} + {2'b00, inflight_q};

  // armed_q keeps the first read off until a clock edge has been seen with
  // reset released, and forces the request low while reset is held.
  assign rd_en      = armed_q && enable && !fifo_empty && (budget < 3'd2);
  assign fifo_rd_en = rd_en;

  always_comb begin
    armed_d    = 1'b1;
    inflight_d = rd_en;
    word_cnt_d = word_cnt_q;
    if (pop) begin
      word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    err_d = err_q | fifo_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b0;
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
    end
  end

  assign word_cnt      = word_cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
module tb_fifo_stream_drain;

  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [CW-1:0] word_cnt;
  logic          err_underflow;

  always #5 clk = ~clk;

  fifo_stream_drain #(
    .FIFO_WIDTH (W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .word_cnt       (word_cnt),
    .err_underflow  (err_underflow)
  );

  // FIFO model: 1-cycle read latency, optional endless counting source.
  logic [15:0] mem [64];
  int   wr_ptr    = 0;
  int   rd_ptr    = 0;
  int   rd_issued = 0;
  int   src_val   = 0;
  logic src_mode  = 1'b0;
  logic model_uf  = 1'b0;
  logic force_uf  = 1'b0;

  assign fifo_empty     = !src_mode && (wr_ptr == rd_ptr);
  assign fifo_underflow = model_uf | force_uf;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_issued <= rd_issued + 1;
      if (src_mode) begin
        fifo_data_out <= src_val[15:0];
        src_val       <= src_val + 1;
      end else if (wr_ptr == rd_ptr) begin
        model_uf <= 1'b1;
      end else begin
        fifo_data_out <= mem[rd_ptr % 64];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr % 64] = v;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    int          npush;
    logic [15:0] base;
    logic        rd;
    logic        vld;
    logic        chk_dat;
    logic [15:0] dat;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic rdy, input int npush,
                              input logic [15:0] base, input logic rd, input logic vld,
                              input logic chk_dat, input logic [15:0] dat,
                              input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.rdy = rdy; v.npush = npush; v.base = base;
    v.rd = rd; v.vld = vld; v.chk_dat = chk_dat; v.dat = dat; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int errs;
    int base;
    logic got;

    // Preloaded stream at full rate, then backpressure with 3 words available.
    //               en    rdy   np base    rd    vld   cd    dat      cnt
    vecs[0]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0,  16'd0);
    vecs[1]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0,  16'd0);
    vecs[2]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h1,  16'd0);
    vecs[3]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h2,  16'd1);
    vecs[4]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h3,  16'd2);
    vecs[5]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h4,  16'd3);
    vecs[6]  = mk(1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0,  16'd4);
    vecs[7]  = mk(1'b1, 1'b0, 3, 16'h11, 1'b1, 1'b0, 1'b0, 16'h0, 16'd4);
    vecs[8]  = mk(1'b1, 1'b0, 0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0,  16'd4);
    vecs[9]  = mk(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h11, 16'd4);
    vecs[10] = mk(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h11, 16'd4);
    vecs[11] = mk(1'b1, 1'b0, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h11, 16'd4);
    vecs[12] = mk(1'b1, 1'b1, 0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h11, 16'd4);
    vecs[13] = mk(1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h12, 16'd5);
    vecs[14] = mk(1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h13, 16'd6);
    vecs[15] = mk(1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0,  16'd7);

    rst     = 1'b1;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(16'(i));

    step(); step();
    @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_err", err_underflow, 0);

    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rd_before_first_edge", fifo_rd_en, 0);

    for (int i = 0; i < 16; i++) begin
      step();
      enable  = vecs[i].en;
      m_ready = vecs[i].rdy;
      for (int k = 0; k < vecs[i].npush; k++) push(vecs[i].base + 16'(k));
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), fifo_rd_en, vecs[i].rd);
      chk($sformatf("v%0d_m_valid", i), m_valid, vecs[i].vld);
      if (vecs[i].chk_dat) chk($sformatf("v%0d_m_data", i), m_data, vecs[i].dat);
      chk($sformatf("v%0d_word_cnt", i), word_cnt, vecs[i].cnt);
    end

    // Enable dropped right after a read is issued: that word still arrives.
    step();
    push(16'h21); push(16'h22);
    enable = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("drop_rd_issue", fifo_rd_en, 1);
    step();
    enable = 1'b0;
    @(negedge clk);
    chk("drop_rd_stop", fifo_rd_en, 0);
    step();
    @(negedge clk);
    chk("drop_vld", m_valid, 1);
    chk("drop_data", m_data, 16'h21);
    step();
    @(negedge clk);
    chk("drop_vld_off", m_valid, 0);
    chk("drop_cnt", word_cnt, 8);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("drop_no_more_rd", fifo_rd_en, 0);
    end
    step();
    enable = 1'b1;
    @(negedge clk);
    chk("resume_rd", fifo_rd_en, 1);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    chk("resume_vld", m_valid, 1);
    chk("resume_data", m_data, 16'h22);
    step();
    @(negedge clk);
    chk("resume_cnt", word_cnt, 9);

    // Empty FIFO with enable held: no read, no underflow.
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      chk("empty_rd_en", fifo_rd_en, 0);
    end
    chk("empty_model_uf", model_uf, 0);
    chk("empty_err", err_underflow, 0);

    // Reset with one word buffered and one in flight.
    step();
    push(16'h31); push(16'h32); push(16'h33); push(16'h34);
    enable = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    chk("mid_rd0", fifo_rd_en, 1);
    step();
    @(negedge clk);
    chk("mid_rd1", fifo_rd_en, 1);
    step();
    chk("mid_head", m_data, 16'h31);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_word_cnt", word_cnt, 0);
    chk("mid_rst_err", err_underflow, 0);
    step();
    rst = 1'b0; m_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("post_rst_vld_seen", got, 1);
    chk("post_rst_first", m_data, 16'h33);
    @(negedge clk);
    chk("post_rst_second", m_data, 16'h34);
    @(negedge clk);
    chk("post_rst_cnt", word_cnt, 2);
    chk("post_rst_idle", m_valid, 0);

    // Counter wrap: 65537 words from the counting source.
    step();
    rst = 1'b1; enable = 1'b0; src_mode = 1'b1;
    step();
    rst = 1'b0;
    base = rd_issued;
    pops = 0;
    errs = 0;
    for (int c = 0; c < 70000; c++) begin
      step();
      enable = ((rd_issued - base) < 65537);
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (m_data !== pops[15:0]) errs++;
        pops++;
      end
      if (pops >= 65537) break;
    end
    chk("wrap_pops", pops, 65537);
    chk("wrap_data_errs", errs, 0);
    repeat (3) step();
    @(negedge clk);
    chk("wrap_word_cnt", word_cnt, 1);
    chk("wrap_idle", m_valid, 0);
    src_mode = 1'b0;

    // Underflow pulse is sticky until reset.
    step();
    force_uf = 1'b1;
    step();
    force_uf = 1'b0;
    @(negedge clk);
    chk("uf_set", err_underflow, 1);
    repeat (5) step();
    chk("uf_hold", err_underflow, 1);
    rst = 1'b1;
    #1;
    chk("uf_clear", err_underflow, 0);
    step();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
